// File: rtl/serdes_lb_pkg.sv
`default_nettype none
// ============================================================================
// serdes_lb_pkg : K-codes, checker states and frame word formatter.  Rev 1.0
// ============================================================================
package serdes_lb_pkg;

   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_1 = 8'h3C;
   localparam logic [7:0] K28_2 = 8'h5C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_6 = 8'hDC;
   localparam logic [7:0] K28_7 = 8'hFC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;

   localparam logic [7:0] FILL_DEFAULT = 8'h4A;
   localparam int         MAX_NBYTES   = 8;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

   // Returns {k[7:0], data[63:0]}; lanes at or above nbytes are zero.
   function automatic logic [71:0] frame_word(
      input logic [7:0] w,
      input logic [2:0] pos,
      input int         nbytes,
      input logic [7:0] kchar,
      input logic [7:0] fill
   );
      logic [63:0] v_data;
      logic [7:0]  v_k;
      v_data = '0;
      v_k    = '0;
      for (int i = 0; i < MAX_NBYTES; i++) begin
         if (i < nbytes) begin
            if (w == 8'd0) begin
               v_data[8*i +: 8] = (pos == 3'(i)) ? kchar : fill;
               v_k[i]           = (pos == 3'(i));
            end else begin
               v_data[8*i +: 8] = w + 8'(i);
            end
         end
      end
      return {v_k, v_data};
   endfunction

endpackage
`default_nettype wire

// File: rtl/serdes_lb_patgen.sv
`default_nettype none
// ============================================================================
// serdes_lb_patgen : frame word counter plus word formatter.  Rev 1.0
// ============================================================================
module serdes_lb_patgen
   import serdes_lb_pkg::*;
#(
   parameter int         NBYTES = 8,
   parameter logic [7:0] KCHAR  = K28_5,
   parameter logic [7:0] FILL   = FILL_DEFAULT,
   parameter int         PERIOD = 16,
   parameter int         PW     = $clog2(NBYTES)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_clr,
   input  logic                i_load,
   input  logic [7:0]          i_load_w,
   input  logic                i_adv,
   input  logic                i_pos_ld,
   input  logic [PW-1:0]       i_pos,
   output logic [7:0]          o_w,
   output logic [8*NBYTES-1:0] o_data,
   output logic [NBYTES-1:0]   o_k
);

   logic [7:0]    r_w;
   logic [PW-1:0] r_pos;
   logic [PW-1:0] w_pos;
   logic [71:0]   w_fw;
   logic          w_unused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w   <= '0;
         r_pos <= '0;
      end else begin
         if (i_clr)
            r_w <= '0;
         else if (i_load)
            r_w <= i_load_w;
         else if (i_adv)
            r_w <= (r_w == 8'(PERIOD - 1)) ? 8'd0 : r_w + 8'd1;
         if (i_pos_ld)
            r_pos <= i_pos;
      end
   end

   // A position being loaded this cycle already applies to the word formatted now.
   assign w_pos  = i_pos_ld ? i_pos : r_pos;
   assign w_fw   = frame_word(r_w, 3'(w_pos), NBYTES, KCHAR, FILL);
   assign o_w    = r_w;
   assign o_data = w_fw[8*NBYTES-1:0];
   assign o_k    = w_fw[64 +: NBYTES];

   assign w_unused = ^w_fw;

endmodule
`default_nettype wire

// File: rtl/serdes_lb_prbs_chk.sv
`default_nettype none
// ============================================================================
// serdes_lb_prbs_chk : framed loopback traffic generator and lock/error checker.
// Rev 1.0
// ============================================================================
module serdes_lb_prbs_chk
   import serdes_lb_pkg::*;
#(
   parameter int         NBYTES    = 8,
   parameter logic [7:0] KCHAR     = K28_5,
   parameter logic [7:0] FILL      = FILL_DEFAULT,
   parameter int         PERIOD    = 16,
   parameter int         LOCK_GOOD = 8,
   parameter int         LOCK_BAD  = 4,
   parameter int         ERR_W     = 16
) (
   input  logic                       ref_clk,
   input  logic                       trx_rstn_i,
   input  logic                       en_i,
   input  logic [$clog2(NBYTES)-1:0]  comma_pos_i,
   input  logic                       force_err_i,
   input  logic                       cnt_clr_i,
   input  logic                       rx_valid_i,
   input  logic [8*NBYTES-1:0]        rx_data_i,
   input  logic [NBYTES-1:0]          rx_k_i,
   output logic [8*NBYTES-1:0]        tx_data_o,
   output logic [NBYTES-1:0]          tx_k_o,
   output logic                       locked_o,
   output logic                       err_o,
   output logic [ERR_W-1:0]           err_cnt_o,
   output logic [31:0]                word_cnt_o
);

   localparam int PW = $clog2(NBYTES);
   localparam int GW = $clog2(LOCK_GOOD + 1);
   localparam int BW = $clog2(LOCK_BAD + 1);
   localparam logic [8*NBYTES-1:0] C_RST_DATA = {{(NBYTES-1){FILL}}, KCHAR};
   localparam logic [NBYTES-1:0]   C_RST_K    = NBYTES'(1);

   // ---------------- generator ----------------
   logic [7:0]          w_tx_w;
   logic [8*NBYTES-1:0] w_tx_data;
   logic [NBYTES-1:0]   w_tx_k;
   logic                w_tx_first;
   logic                w_force;
   logic [8*NBYTES-1:0] r_tx_data;
   logic [NBYTES-1:0]   r_tx_k;

   assign w_tx_first = (w_tx_w == 8'd0);
   assign w_force    = force_err_i & ~w_tx_first;

   serdes_lb_patgen #(
      .NBYTES (NBYTES), .KCHAR (KCHAR), .FILL (FILL), .PERIOD (PERIOD), .PW (PW)
   ) u_tx_gen (
      .clk      (ref_clk),
      .rst_n    (trx_rstn_i),
      .i_clr    (~en_i),
      .i_load   (1'b0),
      .i_load_w (8'd0),
      .i_adv    (en_i),
      .i_pos_ld (w_tx_first),
      .i_pos    (comma_pos_i),
      .o_w      (w_tx_w),
      .o_data   (w_tx_data),
      .o_k      (w_tx_k)
   );

   always_ff @(posedge ref_clk or negedge trx_rstn_i) begin
      if (!trx_rstn_i) begin
         r_tx_data <= C_RST_DATA;
         r_tx_k    <= C_RST_K;
      end else begin
         r_tx_data <= w_tx_data ^ {{(8*NBYTES-1){1'b0}}, w_force};
         r_tx_k    <= w_tx_k;
      end
   end

   assign tx_data_o = r_tx_data;
   assign tx_k_o    = r_tx_k;

   // ---------------- checker ----------------
   logic                r_rx_vld;
   logic [8*NBYTES-1:0] r_rx_data;
   logic [NBYTES-1:0]   r_rx_k;

   always_ff @(posedge ref_clk or negedge trx_rstn_i) begin
      if (!trx_rstn_i) begin
         r_rx_vld  <= 1'b0;
         r_rx_data <= '0;
         r_rx_k    <= '0;
      end else begin
         r_rx_vld  <= rx_valid_i;
         r_rx_data <= rx_data_i;
         r_rx_k    <= rx_k_i;
      end
   end

   logic          w_comma_hit;
   logic [PW-1:0] w_comma_pos;

   always_comb begin
      logic v_match;
      w_comma_hit = 1'b0;
      w_comma_pos = '0;
      v_match     = 1'b0;
      // Walk downwards so the lowest matching lane wins.
      for (int p = NBYTES - 1; p >= 0; p--) begin
         v_match = 1'b1;
         for (int i = 0; i < NBYTES; i++) begin
            if (r_rx_k[i] != (i == p))
               v_match = 1'b0;
            if (r_rx_data[8*i +: 8] != ((i == p) ? KCHAR : FILL))
               v_match = 1'b0;
         end
         if (v_match) begin
            w_comma_hit = 1'b1;
            w_comma_pos = PW'(p);
         end
      end
   end

   chk_state_e          r_state, w_state_nxt;
   logic [GW-1:0]       r_good, w_good_nxt;
   logic [BW-1:0]       r_bad, w_bad_nxt;
   logic                w_err, w_word;
   logic                w_load, w_adv;
   logic                w_match;
   logic [7:0]          w_exp_w;
   logic [8*NBYTES-1:0] w_exp_data;
   logic [NBYTES-1:0]   w_exp_k;
   logic                w_unused;

   assign w_load  = r_rx_vld & (r_state == SEARCH) & w_comma_hit;
   assign w_adv   = r_rx_vld & ((r_state == VERIFY) | (r_state == LOCKED));
   assign w_match = (r_rx_data == w_exp_data) && (r_rx_k == w_exp_k);

   // Expected-word model: reloaded to the word after the comma on a search hit.
   serdes_lb_patgen #(
      .NBYTES (NBYTES), .KCHAR (KCHAR), .FILL (FILL), .PERIOD (PERIOD), .PW (PW)
   ) u_exp_gen (
      .clk      (ref_clk),
      .rst_n    (trx_rstn_i),
      .i_clr    (1'b0),
      .i_load   (w_load),
      .i_load_w (8'd1),
      .i_adv    (w_adv),
      .i_pos_ld (w_load),
      .i_pos    (w_comma_pos),
      .o_w      (w_exp_w),
      .o_data   (w_exp_data),
      .o_k      (w_exp_k)
   );

   assign w_unused = ^w_exp_w;

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_bad_nxt   = r_bad;
      w_err       = 1'b0;
      w_word      = 1'b0;
      if (!r_rx_vld) begin
         w_state_nxt = SEARCH;
         w_good_nxt  = '0;
         w_bad_nxt   = '0;
      end else begin
         case (r_state)
            SEARCH: begin
               if (w_comma_hit) begin
                  w_state_nxt = VERIFY;
                  w_good_nxt  = '0;
               end
            end
            VERIFY: begin
               if (!w_match) begin
                  w_state_nxt = SEARCH;
               end else if (r_good == GW'(LOCK_GOOD - 1)) begin
                  w_state_nxt = LOCKED;
                  w_bad_nxt   = '0;
               end else begin
                  w_good_nxt  = r_good + 1'b1;
               end
            end
            LOCKED: begin
               w_word = 1'b1;
               if (w_match) begin
                  w_bad_nxt = '0;
               end else begin
                  w_err = 1'b1;
                  if (r_bad == BW'(LOCK_BAD - 1))
                     w_state_nxt = SEARCH;
                  else
                     w_bad_nxt = r_bad + 1'b1;
               end
            end
            default: w_state_nxt = SEARCH;
         endcase
      end
   end

   logic             r_err;
   logic [ERR_W-1:0] r_err_cnt;
   logic [31:0]      r_word_cnt;

   always_ff @(posedge ref_clk or negedge trx_rstn_i) begin
      if (!trx_rstn_i) begin
         r_state    <= SEARCH;
         r_good     <= '0;
         r_bad      <= '0;
         r_err      <= 1'b0;
         r_err_cnt  <= '0;
         r_word_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
         r_bad   <= w_bad_nxt;
         r_err   <= w_err;
         // Clear takes priority over a coincident increment.
         if (cnt_clr_i)
            r_err_cnt <= '0;
         else if (w_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
         if (cnt_clr_i)
            r_word_cnt <= '0;
         else if (w_word && (r_word_cnt != '1))
            r_word_cnt <= r_word_cnt + 1'b1;
      end
   end

   assign locked_o   = (r_state == LOCKED);
   assign err_o      = r_err;
   assign err_cnt_o  = r_err_cnt;
   assign word_cnt_o = r_word_cnt;

endmodule
`default_nettype wire

// File: doc/serdes_lb_prbs_chk.md
# serdes_lb_prbs_chk

Parametrised loopback traffic generator and checker for CC_SERDES bring-up. Generates framed 8b/10b traffic (comma word, then a counting payload) for any datapath width. Checks the looped-back RX words against the same model and reports lock, errors and counts. Sits between fabric logic and the CC_SERDES TX_DATA_I/TX_CHAR_IS_K_I and RX_DATA_O/RX_CHAR_IS_K_O ports, in near-end loopback with TX and RX on one clock.

## Interface
Parameters:
- NBYTES, 8: bytes per word; 2/4/8 for 20/40/80-bit datapath.
- KCHAR, 8'hBC: comma control byte (K28.5).
- FILL, 8'h4A: filler byte in comma words.
- PERIOD, 16: words per frame (1 comma + PERIOD-1 payload); range 2..256.
- LOCK_GOOD, 8: consecutive good words required to lock.
- LOCK_BAD, 4: consecutive bad words that drop lock.
- ERR_W, 16: error counter width.

Ports:
- ref_clk  in  1  sole clock.
- trx_rstn_i  in  1  asynchronous, active-low reset.
- en_i  in  1  generator enable.
- comma_pos_i  in  $clog2(NBYTES)  lane carrying KCHAR.
- force_err_i  in  1  corrupt current payload word.
- cnt_clr_i  in  1  synchronous clear of counters.
- rx_valid_i  in  1  RX data usable (RX reset done).
- rx_data_i  in  8*NBYTES  received bytes, lane 0 = [7:0].
- rx_k_i  in  NBYTES  received K flags.
- tx_data_o  out  8*NBYTES  transmit bytes.
- tx_k_o  out  NBYTES  transmit K flags.
- locked_o  out  1  checker locked.
- err_o  out  1  one-cycle pulse per bad word while locked.
- err_cnt_o  out  ERR_W  saturating error count.
- word_cnt_o  out  32  saturating count of words checked while locked.

## Operation
- Frame model: word index w = 0..PERIOD-1, wrapping to 0.
- w=0 is the comma word: lane comma_pos_i = KCHAR with k=1; all other lanes FILL with k=0.
- w>0 is payload: lane i = (w+i) mod 256, all k=0.
- Generator: w advances by one per cycle while en_i=1.
- With en_i=0, w is forced to 0 and the comma word is emitted continuously.
- comma_pos_i is sampled only when w=0 is emitted, and is held for the rest of the frame.
- force_err_i=1 while a payload word is emitted inverts bit 0 of lane 0 for that word only. It is ignored on comma words.
- Checker FSM states: SEARCH, VERIFY, LOCKED.
  - SEARCH: an exact comma match at any lane position latches that position and moves to VERIFY, with expected w=1.
  - VERIFY: each word is compared with the expected word and w advances. A mismatch returns to SEARCH. LOCK_GOOD consecutive matches move to LOCKED.
  - LOCKED: a mismatch pulses err_o, increments err_cnt_o and increments a bad-run counter. A match clears the bad-run counter. Every checked word increments word_cnt_o. LOCK_BAD consecutive mismatches return to SEARCH.
- rx_valid_i=0 in any state: the checker returns to SEARCH and no counting occurs.
- Counters saturate at all-ones. If cnt_clr_i and an increment occur in the same cycle, the clear wins and the result is 0.
- Reset values:
  - tx_data_o = comma word at lane 0; tx_k_o = 1.
  - Checker state = SEARCH.
  - locked_o = 0, err_o = 0, err_cnt_o = 0, word_cnt_o = 0.

## Timing
- TX: all outputs registered. The first payload word appears 2 cycles after en_i rises (comma word first).
- RX: input register stage, then compare, then state/output register. locked_o, err_o and the counters update 2 cycles after the word is at the inputs.
- locked_o rises 2 cycles after the LOCK_GOOD-th good word is presented. It falls 2 cycles after the LOCK_BAD-th bad word is presented.
- rx_valid_i deassertion drops locked_o 2 cycles later.
- Reset deassertion mid-frame is not special: w restarts at 0 and the checker restarts in SEARCH.
- Throughput: one word per clock, no back-pressure.

## Structure
- Package serdes_lb_pkg holds:
  - K-code constants (K28_0..K28_7, K27_7, K29_7, K30_7).
  - Default FILL.
  - State enum {SEARCH, VERIFY, LOCKED}.
  - Function frame_word(w, pos, NBYTES) returning {k, data}.
- Sub-module serdes_lb_patgen: frame counter plus word formatter.
  - Instanced once as the TX generator.
  - Used in the checker's expected-word model: a second counter with load-on-match.

## Test plan
- NBYTES=8, PERIOD=16, comma_pos_i=3, tx looped to rx, rx_valid_i=1:
  - Comma word is 64'h4A4A4A4A_BC4A4A4A with k=8'h08.
  - locked_o rises 2 cycles after the 8th good word.
  - err_cnt_o stays 0.
- Locked, pulse force_err_i for one cycle on w=5:
  - Lane 0 is sent as 8'h04.
  - One err_o pulse occurs; err_cnt_o=1; locked_o stays 1.
- Locked, force_err_i held high for 4 payload words:
  - err_cnt_o=4.
  - locked_o falls after the 4th bad word.
  - Relock after the next comma + 8 good words.
- NBYTES=2, PERIOD=256: payload wrap checked at w=255, where lanes = 8'hFF, 8'h00. No errors.
- Locked, rx_valid_i low for 3 cycles: locked_o = 0 two cycles later, then relocks. Same cycle cnt_clr_i + error gives err_cnt_o = 0.
- trx_rstn_i asserted mid-frame: all outputs return to their reset values immediately (asynchronous).
